// File: rtl/wb_tick_pkg.sv
// Register map, CTRL bit positions, FSM encoding and reset period of the tick scheduler.
// Constants only: no latency, no flow control.
package wb_tick_pkg;
    localparam int CNT_W = 28;

    localparam logic [29:0] ADR_CTRL   = 30'h3ffffff8;
    localparam logic [29:0] ADR_STATUS = 30'h3ffffff9;
    localparam logic [29:0] ADR_PERIOD = 30'h3ffffffa;
    localparam logic [29:0] ADR_COUNT  = 30'h3ffffffb;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_ONESHOT = 1;
    localparam int CTRL_IE      = 2;

    localparam logic [CNT_W-1:0] PERIOD_DEFAULT = 28'h00fffff;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;
endpackage

// File: rtl/wb_tick_counter.sv
// Free-running tick counter, zeroed on expiry; expire is combinational from the registered count.
// Always advances while run=1; clear has priority and takes effect at the next edge.
module wb_tick_counter
    import wb_tick_pkg::*;
(
    input  logic             CLK_I,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             run,
    input  logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] count,
    output logic             expire
);
    // >= rather than == keeps count bounded by period under any sequencing
    assign expire = run && (count >= period);

    always_ff @(posedge CLK_I or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (run) begin
            count <= expire ? '0 : count + 1'b1;
        end
    end
endmodule

// File: rtl/wb_tick_sched.sv
// Wishbone-mapped periodic/one-shot tick scheduler with sticky interrupt; ACK/RTY one cycle after strobe.
// No wait states: every transfer completes in one cycle; PERIOD writes while running are refused with RTY.
module wb_tick_sched
    import wb_tick_pkg::*;
(
    input  logic        CLK_I,
    input  logic        RST_N_I,
    input  logic [29:0] ADR_I,
    input  logic [31:0] DAT_I,
    input  logic        WE_I,
    input  logic        STB_I,
    input  logic        CYC_I,
    output logic [31:0] DAT_O,
    output logic        ACK_O,
    output logic        RTY_O,
    output logic        interrupt_o
);
    logic [1:0]       rst_sync;
    logic             rst_n;
    state_t           state;
    logic [2:0]       ctrl;
    logic [CNT_W-1:0] period;
    logic             irq;
    logic [CNT_W-1:0] count;
    logic             expire;
    logic             start, wr, rd;
    logic             period_busy, period_wr, ctrl_wr, status_rd;
    logic             cnt_clear, cnt_run;
    logic [31:0]      rd_dat;
    logic             unused_dat;

    // Assert passes straight through; release is re-timed to CLK_I
    always_ff @(posedge CLK_I or negedge RST_N_I) begin
        if (!RST_N_I) rst_sync <= 2'b00;
        else          rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_n = rst_sync[1];

    assign start       = CYC_I & STB_I & ~ACK_O & ~RTY_O;
    assign wr          = start & WE_I;
    assign rd          = start & ~WE_I;
    assign period_busy = wr && (ADR_I == ADR_PERIOD) && (state == ST_RUN);
    assign period_wr   = wr && (ADR_I == ADR_PERIOD) && (state != ST_RUN);
    assign ctrl_wr     = wr && (ADR_I == ADR_CTRL);
    assign status_rd   = rd && (ADR_I == ADR_STATUS);
    assign cnt_run     = (state == ST_RUN);
    // Restarting from IDLE/DONE or stopping zeroes the count; re-enabling while running does not
    assign cnt_clear   = ctrl_wr && (!DAT_I[CTRL_EN] || state != ST_RUN);
    assign unused_dat  = ^DAT_I[31:28];

    always_comb begin
        rd_dat = '0;
        case (ADR_I)
            ADR_CTRL:   rd_dat = {29'b0, ctrl};
            ADR_STATUS: rd_dat = {29'b0, state, irq};
            ADR_PERIOD: rd_dat = {4'b0, period};
            ADR_COUNT:  rd_dat = {4'b0, count};
            default:    rd_dat = '0;
        endcase
    end

    wb_tick_counter u_counter (
        .CLK_I  (CLK_I),
        .rst_n  (rst_n),
        .clear  (cnt_clear),
        .run    (cnt_run),
        .period (period),
        .count  (count),
        .expire (expire)
    );

    always_ff @(posedge CLK_I or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            ctrl        <= '0;
            period      <= PERIOD_DEFAULT;
            irq         <= 1'b0;
            ACK_O       <= 1'b0;
            RTY_O       <= 1'b0;
            DAT_O       <= '0;
            interrupt_o <= 1'b0;
        end else begin
            ACK_O       <= start & ~period_busy;
            RTY_O       <= period_busy;
            DAT_O       <= rd ? rd_dat : '0;
            interrupt_o <= irq & ctrl[CTRL_IE];

            // Expiry outranks the clear-on-read of STATUS
            if (expire)         irq <= 1'b1;
            else if (status_rd) irq <= 1'b0;

            if (period_wr) period <= DAT_I[CNT_W-1:0];

            if (expire && ctrl[CTRL_ONESHOT]) begin
                state         <= ST_DONE;
                ctrl[CTRL_EN] <= 1'b0;
            end
            // A software CTRL write overrides a coincident one-shot completion
            if (ctrl_wr) begin
                ctrl  <= DAT_I[2:0];
                state <= DAT_I[CTRL_EN] ? ST_RUN : ST_IDLE;
            end
        end
    end
endmodule

// File: doc/wb_tick_sched.md
WB_TICK_SCHED -- requirements
Module: wb_tick_sched

Interface
REQ-001 SHALL have port CLK_I  input  1  single clock; all state updates on its rising edge.
REQ-002 SHALL have port RST_N_I  input  1  reset; asynchronous assert, active-low.
REQ-003 SHALL have port ADR_I  input  30  Wishbone word address.
REQ-004 SHALL have port DAT_I  input  32  Wishbone write data.
REQ-005 SHALL have port WE_I  input  1  1 = write, 0 = read.
REQ-006 SHALL have ports STB_I and CYC_I  input  1 each  Wishbone strobe and cycle.
REQ-007 SHALL have port DAT_O  output  32  read data, registered, valid while ACK_O=1.
REQ-008 SHALL have port ACK_O  output  1  transfer complete, one-cycle pulse.
REQ-009 SHALL have port RTY_O  output  1  transfer refused, one-cycle pulse, no side effects.
REQ-010 SHALL have port interrupt_o  output  1  sticky expiry interrupt, gated by IE.
REQ-011 SHALL decode these registers: CTRL 30'h3ffffff8 (bit0 EN, bit1 ONESHOT, bit2 IE), STATUS 30'h3ffffff9 (bit0 IRQ, bits2:1 state), PERIOD 30'h3ffffffa (bits27:0), COUNT 30'h3ffffffb (bits27:0, read-only).

Function
REQ-012 SHALL start a bus transfer when CYC_I&STB_I=1 and ACK_O=RTY_O=0; at the next edge it SHALL raise exactly one of ACK_O or RTY_O for one cycle; a strobe held through that cycle SHALL NOT start a second transfer.
REQ-013 SHALL apply a write at the same edge that raises ACK_O; unused DAT_I bits SHALL be ignored.
REQ-014 SHALL return a read as zero-extended register contents on DAT_O at the ACK_O edge; unmapped addresses SHALL ACK with DAT_O=0 and ignore writes.
REQ-015 SHALL answer a PERIOD write while state is RUN with RTY_O; PERIOD SHALL be unchanged.
REQ-016 SHALL answer a COUNT write with ACK_O and SHALL ignore it.
REQ-017 SHALL implement FSM states IDLE (2'b00), RUN (2'b01) and DONE (2'b10).
REQ-018 IDLE->RUN SHALL occur when CTRL.EN is written 1; COUNT SHALL be 0 on entry.
REQ-019 In RUN, COUNT SHALL increment by 1 per cycle; when COUNT==PERIOD it SHALL expire: IRQ set, COUNT set to 0, giving one expiry every PERIOD+1 cycles.
REQ-020 On expiry with ONESHOT=1, the FSM SHALL go RUN->DONE and EN SHALL clear; with ONESHOT=0 it SHALL stay in RUN.
REQ-021 Writing EN=0 from RUN or DONE SHALL go to IDLE with COUNT cleared; IRQ SHALL be kept.
REQ-022 Writing EN=1 in DONE SHALL go to RUN with COUNT=0.
REQ-023 A read of STATUS SHALL clear IRQ at the ACK edge; if an expiry occurs on that same edge, IRQ SHALL end up 1 (set wins) and the read data SHALL show the pre-edge value.
REQ-024 interrupt_o SHALL be registered and SHALL equal IRQ & IE one cycle after either changes.
REQ-025 PERIOD=0 SHALL give an expiry every cycle in RUN; COUNT SHALL never exceed PERIOD.
REQ-026 All counter arithmetic SHALL be 28-bit unsigned with no wrap past PERIOD.

Reset
REQ-027 While RST_N_I=0, outputs SHALL be ACK_O=0, RTY_O=0, interrupt_o=0, DAT_O=0, and state SHALL be IDLE, COUNT=0, IRQ=0, CTRL=0, PERIOD=28'h00fffff.
REQ-028 Reset asserted mid-transfer SHALL abort the transfer with no ACK_O or RTY_O; release SHALL be synchronized internally to CLK_I.

Structure
REQ-029 Package wb_tick_pkg SHALL hold the register addresses, CTRL bit indices, the state enum and the default PERIOD.
REQ-030 The counter/compare SHALL be sub-module wb_tick_counter (inputs clear, run, period; outputs count, expire); the FSM and bus decode SHALL be in wb_tick_sched.

Verification
REQ-031 Reset, then read PERIOD -> ACK_O one cycle later, DAT_O=32'h000fffff; STATUS read -> 0.
REQ-032 Write PERIOD=4, CTRL=3'b101 -> IRQ set every 5 cycles, interrupt_o=1 one cycle later, state stays RUN.
REQ-033 With PERIOD=2, write CTRL=3'b111 -> one expiry, STATUS reads state 2'b10, CTRL.EN reads 0, COUNT holds 0.
REQ-034 In RUN, write PERIOD=7 -> RTY_O pulse, PERIOD still reads old value; after EN=0 the same write -> ACK_O and PERIOD=7.
REQ-035 With PERIOD=0, read STATUS -> DAT_O bit0=1 and IRQ stays 1 (set wins); after EN=0, a second STATUS read clears IRQ and interrupt_o drops one cycle later.
REQ-036 Assert RST_N_I low during a pending write -> no ACK_O, all registers at reset values immediately.
